psl_job_control: RTL and testbench
==================================

PSL_JOB_CONTROL -- requirements
Module: psl_job_control

Interface
REQ-001 SHALL have parameter RESET_CYCLES, default 16, giving the number of cycles afu_rst is held for a PSL reset command (legal 2..255).
REQ-002 SHALL have parameter PARITY_EN, default 1, where 1 enables odd-parity checking of ha_jcom and ha_jea.
REQ-003 SHALL have port ha_pclock  in  1  sole clock; all logic on its rising edge.
REQ-004 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-005 SHALL have port ha_jval  in  1  job command valid, single-cycle.
REQ-006 SHALL have port ha_jcom  in  8  job command code (0x80 RESET, 0x90 START).
REQ-007 SHALL have port ha_jcompar  in  1  odd parity over ha_jcom.
REQ-008 SHALL have port ha_jea  in  64  work element descriptor address.
REQ-009 SHALL have port ha_jeapar  in  1  odd parity over ha_jea.
REQ-010 SHALL have port afu_done  in  1  single-cycle completion pulse from the AFU core.
REQ-011 SHALL have port afu_error  in  64  AFU error code, sampled with afu_done.
REQ-012 SHALL have port afu_rst  out  1  active-high reset to the AFU core.
REQ-013 SHALL have port afu_start  out  1  single-cycle start pulse to the AFU core.
REQ-014 SHALL have port wed  out  64  latched ha_jea of the accepted START.
REQ-015 SHALL have ports ah_jrunning, ah_jdone, ah_jcack, ah_jyield, ah_tbreq, ah_paren  out  1 each, and ah_jerror  out  64, as the PSL job status.

Function
REQ-016 SHALL implement states IDLE, RESETTING, READY, RUNNING, HALTED, all registered.
REQ-017 SHALL drive ah_jcack, ah_jyield and ah_tbreq to constant 0, and ah_paren to PARITY_EN.
REQ-018 SHALL flag a parity error when PARITY_EN=1, ha_jval=1 and either the XOR of {ha_jcom,ha_jcompar} or the XOR of {ha_jea,ha_jeapar} is 0.
REQ-019 SHALL, on a parity error in any state, set ah_jerror to 0x1, pulse ah_jdone the next cycle, clear ah_jrunning, assert afu_rst and enter HALTED; no command in that cycle is acted on.
REQ-020 SHALL, on a RESET with good parity in any state, enter RESETTING, clear ah_jerror and ah_jrunning, and load the hold counter.
REQ-021 SHALL hold afu_rst=1 for exactly RESET_CYCLES cycles, starting the cycle after RESET is sampled.
REQ-022 SHALL, in the first cycle afu_rst is 0 after RESETTING, pulse ah_jdone for one cycle and be in READY.
REQ-023 SHALL restart the counter to the full RESET_CYCLES on a RESET received during RESETTING, with no intermediate ah_jdone.
REQ-024 SHALL, on a START with good parity in READY, latch wed<=ha_jea and pulse afu_start the next cycle, assert ah_jrunning that same cycle, and enter RUNNING.
REQ-025 SHALL, on a START in IDLE, RESETTING, RUNNING or HALTED, set ah_jerror=0x2, pulse ah_jdone, clear ah_jrunning, assert afu_rst and enter HALTED.
REQ-026 SHALL ignore command codes other than 0x80 and 0x90 that have good parity, with no state or output change.
REQ-027 SHALL, on afu_done in RUNNING, latch ah_jerror<=afu_error, clear ah_jrunning and pulse ah_jdone the next cycle, assert afu_rst and enter HALTED.
REQ-028 SHALL ignore afu_done outside RUNNING.
REQ-029 SHALL give a good-parity RESET priority over afu_done in the same cycle: no completion jdone is generated and ah_jerror is cleared.
REQ-030 SHALL hold ah_jerror stable from its ah_jdone pulse until the next accepted RESET.
REQ-031 SHALL hold afu_rst=1 in IDLE and HALTED, and 0 in READY and RUNNING.

Reset
REQ-032 SHALL, while rst=1, force state IDLE, afu_rst=1, counter=0, and afu_start, wed, ah_jrunning, ah_jdone and ah_jerror all 0.
REQ-033 SHALL let rst override any simultaneous ha_jval or afu_done, including mid-RESETTING and mid-RUNNING.

Verification
REQ-034 SHALL cover: rst, then RESET at cycle 0 -> afu_rst high for cycles 1..16, ah_jdone=1 only at cycle 17, state READY.
REQ-035 SHALL cover: READY, START with ha_jea=0x0000_1234_5678_9A00 -> next cycle afu_start=1, ah_jrunning=1, wed=0x0000_1234_5678_9A00.
REQ-036 SHALL cover: RUNNING, afu_done with afu_error=0x5 -> next cycle ah_jrunning=0, ah_jdone=1, ah_jerror=0x5, afu_rst=1.
REQ-037 SHALL cover: READY, ha_jcom=0x90 with ha_jcompar=0 -> ah_jerror=0x1, ah_jdone pulse, no afu_start.
REQ-038 SHALL cover: RUNNING, RESET and afu_done in the same cycle -> no completion jdone, ah_jerror=0, and jdone only at the end of the 16-cycle hold.
REQ-039 SHALL cover: RESET at cycle 0, second RESET at cycle 5 -> afu_rst held through cycle 21, single ah_jdone at cycle 22.

Source files
------------

// File: rtl/psl_job_control.sv
// PSL job-control sequencer: decodes PSL job commands and parity, and drives
// the AFU core reset/start along with the PSL job status.
module psl_job_control #(
  parameter int unsigned RESET_CYCLES = 16,
  parameter int unsigned PARITY_EN    = 1
) (
  input  logic        ha_pclock,
  input  logic        rst,
  input  logic        ha_jval,
  input  logic [7:0]  ha_jcom,
  input  logic        ha_jcompar,
  input  logic [63:0] ha_jea,
  input  logic        ha_jeapar,
  input  logic        afu_done,
  input  logic [63:0] afu_error,
  output logic        afu_rst,
  output logic        afu_start,
  output logic [63:0] wed,
  output logic        ah_jrunning,
  output logic        ah_jdone,
  output logic        ah_jcack,
  output logic        ah_jyield,
  output logic        ah_tbreq,
  output logic        ah_paren,
  output logic [63:0] ah_jerror
);

  localparam int unsigned CNT_W = 8;
  localparam int unsigned ERR_W = 64;
  localparam logic [7:0]       CMD_RESET  = 8'h80;
  localparam logic [7:0]       CMD_START  = 8'h90;
  localparam logic [CNT_W-1:0] HOLD_LOAD  = CNT_W'(RESET_CYCLES - 1);
  localparam logic [ERR_W-1:0] ERR_PARITY = ERR_W'(1);
  localparam logic [ERR_W-1:0] ERR_SEQ    = ERR_W'(2);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_RESETTING = 3'd1,
    ST_READY     = 3'd2,
    ST_RUNNING   = 3'd3,
    ST_HALTED    = 3'd4
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] hold_cnt;

  logic             par_err_c;
  logic             is_reset_c;
  logic             is_start_c;
  logic             halt_c;
  logic [ERR_W-1:0] halt_err_c;

  assign ah_jcack  = 1'b0;
  assign ah_jyield = 1'b0;
  assign ah_tbreq  = 1'b0;
  assign ah_paren  = (PARITY_EN != 0);

  // Command decode; a parity error masks the command entirely.
  always_comb begin
    par_err_c  = 1'b0;
    is_reset_c = 1'b0;
    is_start_c = 1'b0;
    if (PARITY_EN != 0) begin
      par_err_c = ha_jval && (!(^{ha_jcom, ha_jcompar}) || !(^{ha_jea, ha_jeapar}));
    end
    is_reset_c = ha_jval && !par_err_c && (ha_jcom == CMD_RESET);
    is_start_c = ha_jval && !par_err_c && (ha_jcom == CMD_START);
  end

  // Halt causes in priority order: parity, out-of-sequence START, AFU completion.
  always_comb begin
    halt_c     = 1'b0;
    halt_err_c = '0;
    if (par_err_c) begin
      halt_c     = 1'b1;
      halt_err_c = ERR_PARITY;
    end else if (is_start_c && (state != ST_READY)) begin
      halt_c     = 1'b1;
      halt_err_c = ERR_SEQ;
    end else if (!is_reset_c && !is_start_c && (state == ST_RUNNING) && afu_done) begin
      halt_c     = 1'b1;
      halt_err_c = afu_error;
    end
  end

  always_ff @(posedge ha_pclock) begin
    if (rst) begin
      state       <= ST_IDLE;
      hold_cnt    <= '0;
      afu_rst     <= 1'b1;
      afu_start   <= 1'b0;
      wed         <= '0;
      ah_jrunning <= 1'b0;
      ah_jdone    <= 1'b0;
      ah_jerror   <= '0;
    end else begin
      afu_start <= 1'b0;
      ah_jdone  <= 1'b0;
      if (halt_c) begin
        state       <= ST_HALTED;
        afu_rst     <= 1'b1;
        ah_jrunning <= 1'b0;
        ah_jdone    <= 1'b1;
        ah_jerror   <= halt_err_c;
      end else if (is_reset_c) begin
        state       <= ST_RESETTING;
        hold_cnt    <= HOLD_LOAD;
        afu_rst     <= 1'b1;
        ah_jrunning <= 1'b0;
        ah_jerror   <= '0;
      end else if (is_start_c) begin
        // Only reachable in READY; other states were turned into a halt above.
        state       <= ST_RUNNING;
        wed         <= ha_jea;
        afu_start   <= 1'b1;
        ah_jrunning <= 1'b1;
      end else begin
        case (state)
          ST_RESETTING: begin
            if (hold_cnt == '0) begin
              state    <= ST_READY;
              afu_rst  <= 1'b0;
              ah_jdone <= 1'b1;
            end else begin
              hold_cnt <= hold_cnt - CNT_W'(1);
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_psl_job_control.sv
// Scoreboard bench for psl_job_control: stimulus queues expected outputs by
// cycle number; a negedge monitor pops and compares them.
module tb_psl_job_control;

  logic        ha_pclock = 1'b0;
  logic        rst;
  logic        ha_jval;
  logic [7:0]  ha_jcom;
  logic        ha_jcompar;
  logic [63:0] ha_jea;
  logic        ha_jeapar;
  logic        afu_done;
  logic [63:0] afu_error;
  logic        afu_rst;
  logic        afu_start;
  logic [63:0] wed;
  logic        ah_jrunning;
  logic        ah_jdone;
  logic        ah_jcack;
  logic        ah_jyield;
  logic        ah_tbreq;
  logic        ah_paren;
  logic [63:0] ah_jerror;

  psl_job_control #(.RESET_CYCLES(16), .PARITY_EN(1)) dut (
    .ha_pclock  (ha_pclock),
    .rst        (rst),
    .ha_jval    (ha_jval),
    .ha_jcom    (ha_jcom),
    .ha_jcompar (ha_jcompar),
    .ha_jea     (ha_jea),
    .ha_jeapar  (ha_jeapar),
    .afu_done   (afu_done),
    .afu_error  (afu_error),
    .afu_rst    (afu_rst),
    .afu_start  (afu_start),
    .wed        (wed),
    .ah_jrunning(ah_jrunning),
    .ah_jdone   (ah_jdone),
    .ah_jcack   (ah_jcack),
    .ah_jyield  (ah_jyield),
    .ah_tbreq   (ah_tbreq),
    .ah_paren   (ah_paren),
    .ah_jerror  (ah_jerror)
  );

  always #5 ha_pclock = ~ha_pclock;

  typedef struct {
    int          cyc;
    logic        rst;
    logic        run;
    logic        done;
    logic        st;
    logic [63:0] err;
  } snap_t;

  typedef struct {
    int          cyc;
    logic [63:0] val;
  } ev_t;

  snap_t snap_q[$];
  ev_t   jdone_q[$];
  ev_t   start_q[$];

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  bit finish_req = 1'b0;
  bit end_done = 1'b0;

  always @(posedge ha_pclock) cyc <= cyc + 1;

  task automatic push_snap(input int c, input logic r, input logic run, input logic d,
                           input logic st, input logic [63:0] e);
    snap_t s;
    s.cyc = c; s.rst = r; s.run = run; s.done = d; s.st = st; s.err = e;
    snap_q.push_back(s);
  endtask

  task automatic push_jdone(input int c, input logic [63:0] e);
    ev_t v;
    v.cyc = c; v.val = e;
    jdone_q.push_back(v);
  endtask

  task automatic push_start(input int c, input logic [63:0] ea);
    ev_t v;
    v.cyc = c; v.val = ea;
    start_q.push_back(v);
  endtask

  // afu_rst held high for cycles c+1 .. c+n with all status quiet.
  task automatic push_hold(input int c, input int n, input logic [63:0] e);
    for (int k = 1; k <= n; k++) push_snap(c + k, 1'b1, 1'b0, 1'b0, 1'b0, e);
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) begin
      @(posedge ha_pclock);
      #1;
    end
  endtask

  task automatic send(input logic [7:0] cmd, input logic [63:0] ea, input bit bad_c,
                      input bit bad_e, input bit done, input logic [63:0] aerr,
                      output int c);
    c          = cyc;
    ha_jval    = 1'b1;
    ha_jcom    = cmd;
    ha_jcompar = (~^cmd) ^ bad_c;
    ha_jea     = ea;
    ha_jeapar  = (~^ea) ^ bad_e;
    afu_done   = done;
    afu_error  = aerr;
    @(posedge ha_pclock);
    #1;
    ha_jval  = 1'b0;
    afu_done = 1'b0;
  endtask

  task automatic pulse_done(input logic [63:0] aerr, output int c);
    c         = cyc;
    afu_done  = 1'b1;
    afu_error = aerr;
    @(posedge ha_pclock);
    #1;
    afu_done = 1'b0;
  endtask

  task automatic do_reset();
    int c;
    send(8'h80, 64'h0, 1'b0, 1'b0, 1'b0, 64'h0, c);
    push_hold(c, 16, 64'h0);
    push_snap(c + 17, 1'b0, 1'b0, 1'b1, 1'b0, 64'h0);
    push_jdone(c + 17, 64'h0);
    push_snap(c + 18, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0);
    wait_cyc(c + 19);
  endtask

  task automatic do_start(input logic [63:0] ea);
    int c;
    send(8'h90, ea, 1'b0, 1'b0, 1'b0, 64'h0, c);
    push_snap(c + 1, 1'b0, 1'b1, 1'b0, 1'b1, 64'h0);
    push_start(c + 1, ea);
    push_snap(c + 2, 1'b0, 1'b1, 1'b0, 1'b0, 64'h0);
    wait_cyc(c + 3);
  endtask

  // Monitor: event-driven pops for jdone/start pulses, cycle-tagged snapshots.
  always @(negedge ha_pclock) begin
    snap_t       s;
    ev_t         v;
    logic [71:0] act;
    logic [71:0] exp;
    if (ah_jdone) begin
      checks++;
      if (jdone_q.size() == 0) begin
        errors++;
        $display("FAIL jdone_unexpected cycle=%0d jerror=%h", cyc, ah_jerror);
      end else begin
        v = jdone_q.pop_front();
        if (v.cyc != cyc || v.val != ah_jerror) begin
          errors++;
          $display("FAIL jdone cycle=%0d jerror=%h required cycle=%0d jerror=%h",
                   cyc, ah_jerror, v.cyc, v.val);
        end
      end
    end
    if (afu_start) begin
      checks++;
      if (start_q.size() == 0) begin
        errors++;
        $display("FAIL start_unexpected cycle=%0d wed=%h", cyc, wed);
      end else begin
        v = start_q.pop_front();
        if (v.cyc != cyc || v.val != wed || !ah_jrunning) begin
          errors++;
          $display("FAIL start cycle=%0d wed=%h run=%b required cycle=%0d wed=%h run=1",
                   cyc, wed, ah_jrunning, v.cyc, v.val);
        end
      end
    end
    while (snap_q.size() > 0 && snap_q[0].cyc <= cyc) begin
      s = snap_q.pop_front();
      checks++;
      act = {afu_rst, ah_jrunning, ah_jdone, afu_start,
             ah_jcack, ah_jyield, ah_tbreq, ah_paren, ah_jerror};
      exp = {s.rst, s.run, s.done, s.st, 4'b0001, s.err};
      if (s.cyc != cyc) begin
        errors++;
        $display("FAIL snap_missed cycle=%0d required cycle=%0d", cyc, s.cyc);
      end else if (act !== exp) begin
        errors++;
        $display("FAIL snap cycle=%0d rst/run/done/start/const/err=%h required %h",
                 cyc, act, exp);
      end
    end
    if (finish_req && !end_done) begin
      end_done = 1'b1;
      checks++;
      if (snap_q.size() != 0 || jdone_q.size() != 0 || start_q.size() != 0) begin
        errors++;
        $display("FAIL leftover snap=%0d jdone=%0d start=%0d required 0/0/0",
                 snap_q.size(), jdone_q.size(), start_q.size());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog cycle=%0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int c;
    int c2;
    rst = 1'b1; ha_jval = 1'b0; ha_jcom = '0; ha_jcompar = 1'b1;
    ha_jea = '0; ha_jeapar = 1'b1; afu_done = 1'b0; afu_error = '0;
    repeat (2) @(posedge ha_pclock);
    #1;
    push_snap(cyc, 1'b1, 1'b0, 1'b0, 1'b0, 64'h0);
    rst = 1'b0;
    push_snap(cyc + 1, 1'b1, 1'b0, 1'b0, 1'b0, 64'h0);
    wait_cyc(cyc + 2);

    // RESET hold of 16 cycles, jdone on the 17th
    do_reset();
    // START latches wed and pulses afu_start
    do_start(64'h0000_1234_5678_9A00);
    // AFU completion with error code 5
    pulse_done(64'h5, c);
    push_snap(c + 1, 1'b1, 1'b0, 1'b1, 1'b0, 64'h5);
    push_jdone(c + 1, 64'h5);
    push_snap(c + 2, 1'b1, 1'b0, 1'b0, 1'b0, 64'h5);
    wait_cyc(c + 3);
    // START while HALTED is a sequence error
    send(8'h90, 64'hABCD, 1'b0, 1'b0, 1'b0, 64'h0, c);
    push_snap(c + 1, 1'b1, 1'b0, 1'b1, 1'b0, 64'h2);
    push_jdone(c + 1, 64'h2);
    push_snap(c + 2, 1'b1, 1'b0, 1'b0, 1'b0, 64'h2);
    wait_cyc(c + 3);
    // RESET, with an afu_done during the hold that must be ignored
    send(8'h80, 64'h0, 1'b0, 1'b0, 1'b0, 64'h0, c);
    push_hold(c, 16, 64'h0);
    push_snap(c + 17, 1'b0, 1'b0, 1'b1, 1'b0, 64'h0);
    push_jdone(c + 17, 64'h0);
    wait_cyc(c + 5);
    pulse_done(64'h77, c2);
    wait_cyc(c + 18);
    // START with bad command parity in READY
    send(8'h90, 64'h1000, 1'b1, 1'b0, 1'b0, 64'h0, c);
    push_snap(c + 1, 1'b1, 1'b0, 1'b1, 1'b0, 64'h1);
    push_jdone(c + 1, 64'h1);
    push_snap(c + 2, 1'b1, 1'b0, 1'b0, 1'b0, 64'h1);
    wait_cyc(c + 3);
    // Unknown code ignored, then RESET beats a simultaneous afu_done
    do_reset();
    send(8'h55, 64'h0, 1'b0, 1'b0, 1'b0, 64'h0, c);
    push_snap(c + 1, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0);
    push_snap(c + 2, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0);
    wait_cyc(c + 3);
    do_start(64'hFEDC_BA98_7654_3210);
    send(8'h80, 64'h0, 1'b0, 1'b0, 1'b1, 64'hDEAD, c);
    push_hold(c, 16, 64'h0);
    push_snap(c + 17, 1'b0, 1'b0, 1'b1, 1'b0, 64'h0);
    push_jdone(c + 17, 64'h0);
    wait_cyc(c + 18);
    // Second RESET five cycles in restarts the hold
    send(8'h80, 64'h0, 1'b0, 1'b0, 1'b0, 64'h0, c);
    push_hold(c, 21, 64'h0);
    push_snap(c + 22, 1'b0, 1'b0, 1'b1, 1'b0, 64'h0);
    push_jdone(c + 22, 64'h0);
    push_snap(c + 23, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0);
    wait_cyc(c + 5);
    send(8'h80, 64'h0, 1'b0, 1'b0, 1'b0, 64'h0, c2);
    wait_cyc(c + 24);
    // START while RUNNING is a sequence error
    do_start(64'h0000_0000_CAFE_0040);
    send(8'h90, 64'h8, 1'b0, 1'b0, 1'b0, 64'h0, c);
    push_snap(c + 1, 1'b1, 1'b0, 1'b1, 1'b0, 64'h2);
    push_jdone(c + 1, 64'h2);
    wait_cyc(c + 2);
    // RESET with bad ea parity is a parity error, not a reset
    send(8'h80, 64'h3, 1'b0, 1'b1, 1'b0, 64'h0, c);
    push_snap(c + 1, 1'b1, 1'b0, 1'b1, 1'b0, 64'h1);
    push_jdone(c + 1, 64'h1);
    push_snap(c + 17, 1'b1, 1'b0, 1'b0, 1'b0, 64'h1);
    wait_cyc(c + 18);
    // rst overrides afu_done mid-RUNNING; then START in IDLE errors
    do_reset();
    do_start(64'h0000_0000_0000_0100);
    c = cyc;
    rst = 1'b1; afu_done = 1'b1; afu_error = 64'h9;
    @(posedge ha_pclock);
    #1;
    rst = 1'b0; afu_done = 1'b0;
    push_snap(c + 1, 1'b1, 1'b0, 1'b0, 1'b0, 64'h0);
    push_snap(c + 2, 1'b1, 1'b0, 1'b0, 1'b0, 64'h0);
    wait_cyc(c + 3);
    send(8'h90, 64'h20, 1'b0, 1'b0, 1'b0, 64'h0, c);
    push_snap(c + 1, 1'b1, 1'b0, 1'b1, 1'b0, 64'h2);
    push_jdone(c + 1, 64'h2);
    wait_cyc(c + 3);

    finish_req = 1'b1;
    repeat (3) @(posedge ha_pclock);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
